// File: rtl/dmem_arb_pkg.sv
// Shared constants and bus payload type for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned CNT_W          = 4;
    localparam logic [31:0] ADDR_LIMIT_DEF = 32'h003F_FFFF;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_PM   = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } mem_req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned W     = CNT_W,
    parameter int unsigned LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(LIMIT))) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the CPU and the pattern-matching
// peripheral: CPU priority, anti-starvation for PM, bounded PM lock bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned LOCK_MAX   = 8,
    parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_we,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        pm_req,
    input  logic        pm_lock,
    input  logic [31:0] pm_addr,
    input  logic [31:0] pm_wdata,
    input  logic [3:0]  pm_we,
    output logic        pm_gnt,
    output logic [31:0] pm_rdata,
    output logic        pm_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    input  logic [31:0] drdata,
    output logic [1:0]  owner
);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_r;
    logic             lock_nxt;
    logic             grant_cpu;
    logic             grant_pm;
    logic             sel_err;
    mem_req_t         cpu_bus;
    mem_req_t         pm_bus;
    mem_req_t         sel_bus;

    assign cpu_bus = '{addr: cpu_addr, wdata: cpu_wdata, we: cpu_we};
    assign pm_bus  = '{addr: pm_addr,  wdata: pm_wdata,  we: pm_we};

    // Priority grant; reset gates every grant off combinationally.
    always_comb begin
        grant_cpu = 1'b0;
        grant_pm  = 1'b0;
        if (reset) begin
            if (lock_r && pm_req && (lock_cnt < CNT_W'(LOCK_MAX))) begin
                grant_pm = 1'b1;
            end else if (pm_req && (wait_cnt == CNT_W'(MAX_WAIT))) begin
                grant_pm = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (pm_req) begin
                grant_pm = 1'b1;
            end
        end
    end

    // Data path: granted port drives dmem; out-of-range accesses are squashed.
    always_comb begin
        sel_bus = '0;
        if (grant_cpu) begin
            sel_bus = cpu_bus;
        end else if (grant_pm) begin
            sel_bus = pm_bus;
        end
        sel_err   = sel_bus.addr > ADDR_LIMIT;
        daddr     = sel_bus.addr;
        dwdata    = sel_bus.wdata;
        dwe       = sel_err ? 4'h0 : sel_bus.we;
        cpu_ready = grant_cpu;
        pm_gnt    = grant_pm;
        cpu_err   = grant_cpu && sel_err;
        pm_err    = grant_pm && sel_err;
        cpu_rdata = (grant_cpu && !sel_err) ? drdata : 32'h0;
        pm_rdata  = (grant_pm && !sel_err) ? drdata : 32'h0;
    end

    // A CPU grant while locked can only be the cap slot, which ends the burst.
    always_comb begin
        lock_nxt = lock_r;
        if (!pm_req) begin
            lock_nxt = 1'b0;
        end else if (grant_pm) begin
            lock_nxt = pm_lock;
        end else if (grant_cpu && lock_r) begin
            lock_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_r <= 1'b0;
            owner  <= OWN_NONE;
        end else begin
            lock_r <= lock_nxt;
            owner  <= grant_cpu ? OWN_CPU : (grant_pm ? OWN_PM : OWN_NONE);
        end
    end

    sat_counter #(.W(CNT_W), .LIMIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (pm_req && !grant_pm),
        .clr   (!pm_req || grant_pm),
        .cnt   (wait_cnt)
    );

    sat_counter #(.W(CNT_W), .LIMIT(LOCK_MAX)) u_lock_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (grant_pm && pm_lock),
        .clr   (!lock_nxt),
        .cnt   (lock_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a cycle-level
// behavioural model of the grant rules and a reference memory image.
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned LOCK_MAX = 8;
    localparam logic [31:0] LIMIT    = 32'h003F_FFFF;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, pm_req, pm_lock;
    logic [31:0] cpu_addr, cpu_wdata, pm_addr, pm_wdata;
    logic [3:0]  cpu_we, pm_we;
    logic        cpu_ready, cpu_err, pm_gnt, pm_err;
    logic [31:0] cpu_rdata, pm_rdata, daddr, dwdata, drdata;
    logic [3:0]  dwe;
    logic [1:0]  owner;

    logic [31:0] dmem_arr [256];
    logic [31:0] ref_mem  [256];

    int          tests, fails;
    int unsigned m_wait, m_lcnt;
    bit          m_lock;
    logic [1:0]  m_owner;
    bit          e_cpu, e_pm;
    logic [31:0] before0;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .pm_req(pm_req), .pm_lock(pm_lock), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .pm_we(pm_we), .pm_gnt(pm_gnt), .pm_rdata(pm_rdata), .pm_err(pm_err),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory stand-in; aliases on address bits [9:2].
    assign drdata = dmem_arr[daddr[9:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dwe[b]) dmem_arr[daddr[9:2]][8*b +: 8] = dwdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 7))
            0:       return 32'h0040_0000 | (32'($urandom_range(0, 255)) << 2);
            1:       return 32'h003F_FFFC;
            default: return 32'($urandom_range(0, 255)) << 2;
        endcase
    endfunction

    task automatic new_cpu();
        cpu_addr = rnd_addr(); cpu_wdata = $urandom; cpu_we = 4'($urandom_range(0, 15));
    endtask

    task automatic new_pm();
        pm_addr = rnd_addr(); pm_wdata = $urandom; pm_we = 4'($urandom_range(0, 15));
    endtask

    // Sample outputs against the model, then advance the model past the coming posedge.
    task automatic step();
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_we;
        bit          e_err, any;
        #1;
        if (!rst_n) begin
            m_wait = 0; m_lcnt = 0; m_lock = 0; m_owner = 2'b00;
        end
        e_cpu = 0; e_pm = 0;
        if (rst_n) begin
            if (m_lock && pm_req && m_lcnt < LOCK_MAX) e_pm = 1;
            else if (pm_req && m_wait == MAX_WAIT)     e_pm = 1;
            else if (cpu_req)                          e_cpu = 1;
            else if (pm_req)                           e_pm = 1;
        end
        any    = e_cpu || e_pm;
        e_addr = e_cpu ? cpu_addr  : (e_pm ? pm_addr  : 32'h0);
        e_wd   = e_cpu ? cpu_wdata : (e_pm ? pm_wdata : 32'h0);
        e_err  = any && (e_addr > LIMIT);
        e_we   = (!any || e_err) ? 4'h0 : (e_cpu ? cpu_we : pm_we);
        e_rd   = (any && !e_err) ? ref_mem[e_addr[9:2]] : 32'h0;
        chk("cpu_ready", 32'(cpu_ready), 32'(e_cpu));
        chk("pm_gnt",    32'(pm_gnt),    32'(e_pm));
        chk("cpu_err",   32'(cpu_err),   32'(e_cpu && e_err));
        chk("pm_err",    32'(pm_err),    32'(e_pm && e_err));
        chk("daddr",     daddr,          e_addr);
        chk("dwdata",    dwdata,         e_wd);
        chk("dwe",       32'(dwe),       32'(e_we));
        chk("cpu_rdata", cpu_rdata,      e_cpu ? e_rd : 32'h0);
        chk("pm_rdata",  pm_rdata,       e_pm ? e_rd : 32'h0);
        chk("owner",     32'(owner),     32'(m_owner));
        if (rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (e_we[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
            end
            m_owner = e_cpu ? 2'b01 : (e_pm ? 2'b10 : 2'b00);
            if (!pm_req) begin
                m_wait = 0; m_lock = 0; m_lcnt = 0;
            end else if (e_pm) begin
                m_wait = 0;
                if (pm_lock) begin
                    m_lock = 1;
                    m_lcnt = (m_lcnt < LOCK_MAX) ? m_lcnt + 1 : LOCK_MAX;
                end else begin
                    m_lock = 0; m_lcnt = 0;
                end
            end else begin
                m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
                if (e_cpu && m_lock) begin
                    m_lock = 0; m_lcnt = 0;
                end
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        m_wait = 0; m_lcnt = 0; m_lock = 0; m_owner = 2'b00; e_cpu = 0; e_pm = 0;
        for (int i = 0; i < 256; i++) begin
            dmem_arr[i] = $urandom;
            ref_mem[i]  = dmem_arr[i];
        end

        // Reset held low with both ports requesting writes.
        rst_n = 0; cpu_req = 1; pm_req = 1; pm_lock = 0;
        new_cpu(); new_pm();
        cpu_addr = 32'h40; pm_addr = 32'h44; cpu_we = 4'hF; pm_we = 4'hF;
        @(negedge clk);
        step();
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_pm_gnt",    32'(pm_gnt),    32'd0);
        chk("rst_dwe",       32'(dwe),       32'd0);
        chk("rst_owner",     32'(owner),     32'd0);
        @(negedge clk);
        rst_n = 1;
        step();
        chk("first_cpu_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk);

        // CPU write, PM read-back, owner reflects PM one cycle later.
        cpu_req = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEAD_BEEF; cpu_we = 4'hF; pm_req = 0;
        step();
        @(negedge clk);
        cpu_req = 0; pm_req = 1; pm_addr = 32'h100; pm_we = 4'h0;
        step();
        chk("readback_pm_rdata", pm_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        pm_req = 0;
        step();
        chk("readback_owner", 32'(owner), 32'd2);
        @(negedge clk);

        // Continuous contention: PM force-granted every fifth cycle.
        cpu_req = 1; pm_req = 1; pm_lock = 0; new_cpu(); new_pm();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("contend_pm_gnt",    32'(pm_gnt),    32'(i % 5 == 0));
            chk("contend_cpu_ready", 32'(cpu_ready), 32'(i % 5 != 0));
            @(negedge clk);
            if (e_cpu) new_cpu();
            if (e_pm) new_pm();
        end

        // Locked burst capped at LOCK_MAX grants, one CPU slot, then normal pattern.
        for (int i = 1; i <= 22; i++) begin
            pm_lock = (i <= 16);
            step();
            chk("burst_pm_gnt", 32'(pm_gnt),
                32'((i >= 5 && i <= 12) || i == 17 || i == 22));
            @(negedge clk);
            if (e_cpu) new_cpu();
            if (e_pm) new_pm();
        end

        // Range check at and beyond the address limit.
        cpu_req = 0; pm_req = 1; pm_lock = 0;
        pm_addr = 32'h0040_0000; pm_wdata = 32'h1234_5678; pm_we = 4'hF;
        before0 = dmem_arr[0];
        step();
        chk("oor_pm_gnt",   32'(pm_gnt),  32'd1);
        chk("oor_pm_err",   32'(pm_err),  32'd1);
        chk("oor_dwe",      32'(dwe),     32'd0);
        chk("oor_pm_rdata", pm_rdata,     32'd0);
        @(negedge clk);
        pm_addr = 32'h003F_FFFC; pm_we = 4'h0;
        step();
        chk("edge_pm_err",   32'(pm_err), 32'd0);
        chk("oor_mem_intact", dmem_arr[0], before0);
        @(negedge clk);
        pm_req = 0; cpu_req = 1; cpu_addr = 32'h0040_0004; cpu_we = 4'h0;
        step();
        chk("oor_cpu_err",   32'(cpu_err), 32'd1);
        chk("oor_cpu_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk);

        // Randomized traffic; unserved requests are held stable.
        cpu_req = 0; pm_req = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(cpu_req && !e_cpu)) begin
                cpu_req = 1'($urandom_range(0, 1)); new_cpu();
            end
            if (!(pm_req && !e_pm)) begin
                pm_req = 1'($urandom_range(0, 1)); new_pm();
                pm_lock = ($urandom_range(0, 3) != 0);
            end
            step();
            @(negedge clk);
        end

        // Reset mid-burst with lock_cnt at 3.
        cpu_req = 0; pm_req = 0;
        step();
        @(negedge clk);
        pm_req = 1; pm_lock = 1; pm_addr = 32'h200; pm_we = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("preburst_pm_gnt", 32'(pm_gnt), 32'd1);
            @(negedge clk);
        end
        rst_n = 0; cpu_req = 1; cpu_addr = 32'h204; cpu_we = 4'hF;
        step();
        chk("midrst_pm_gnt",    32'(pm_gnt),    32'd0);
        chk("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("midrst_dwe",       32'(dwe),       32'd0);
        chk("midrst_owner",     32'(owner),     32'd0);
        @(negedge clk);
        rst_n = 1;
        step();
        chk("postrst_cpu_ready", 32'(cpu_ready), 32'd1);
        chk("postrst_pm_gnt",    32'(pm_gnt),    32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
